// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops and a WIDTH-cycle
// shift-add multiplier, with a registered result held until the consumer takes it.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               zero_reg;
    logic               carry_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;

    logic [WIDTH-1:0]   simple_y;
    logic               simple_carry;
    logic [WIDTH:0]     sum_ext;

    assign sum_ext = {1'b0, a} + {1'b0, b};

    // Result of every non-multiply opcode, computed straight from the inputs
    // so it can be captured on the acceptance edge.
    always_comb begin
        simple_y     = '0;
        simple_carry = 1'b0;
        case (select)
            OP_ADD: begin
                simple_y     = sum_ext[WIDTH-1:0];
                simple_carry = sum_ext[WIDTH];
            end
            OP_AND:  simple_y = a & b;
            OP_OR:   simple_y = a | b;
            OP_XOR:  simple_y = a ^ b;
            OP_SLT:  simple_y[0] = (a < b);
            OP_PASS: simple_y = a;
            default: simple_y = '0;
        endcase
    end

    assign acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            y_reg         <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (select == OP_MUL) begin
                            state_reg  <= MUL;
                            busy_reg   <= 1'b1;
                            cnt_reg    <= '0;
                            mcand_reg  <= {{WIDTH{1'b0}}, a};
                            mplier_reg <= b;
                            acc_reg    <= '0;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            y_reg         <= simple_y;
                            zero_reg      <= (simple_y == '0);
                            carry_reg     <= simple_carry;
                        end
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        // Final step: publish the product taken from this step's sum.
                        cnt_reg       <= '0;
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        y_reg         <= acc_next[WIDTH-1:0];
                        zero_reg      <= (acc_next[WIDTH-1:0] == '0);
                        carry_reg     <= |acc_next[2*WIDTH-1:WIDTH];
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign y         = y_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   select;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero;
    logic         carry;
    logic         busy;

    int asserts = 0;
    int fails   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .carry     (carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready"},  64'(in_ready),  64'd1);
        check({tag, " busy"},      64'(busy),      64'd0);
    endtask

    // Non-multiply op: accept, expect result one cycle later, then consume.
    task automatic run_simple(input string tag, input logic [2:0] sel,
                              input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] ey, input logic ez, input logic ec);
        select = sel; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " in_ready"},  64'(in_ready),  64'd0);
        check({tag, " y"},         64'(y),         64'(ey));
        check({tag, " zero"},      64'(zero),      64'(ez));
        check({tag, " carry"},     64'(carry),     64'(ec));
        $display("txn %s: sel=%0d a=0x%h b=0x%h y=0x%h zero=%0d carry=%0d",
                 tag, sel, va, vb, y, zero, carry);
        step();
        check_idle({tag, " after consume"});
    endtask

    // Multiply: busy for cycles 1..W, result at cycle W+1, then consume.
    task automatic run_mul(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] ey, input logic ez, input logic ec);
        select = 3'b110; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a = '1; b = '1; select = 3'b001;
        for (int i = 1; i <= W; i++) begin
            check({tag, " busy"},      64'(busy),      64'd1);
            check({tag, " out_valid"}, 64'(out_valid), 64'd0);
            step();
        end
        check({tag, " done out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " done busy"},      64'(busy),      64'd0);
        check({tag, " y"},              64'(y),         64'(ey));
        check({tag, " zero"},           64'(zero),      64'(ez));
        check({tag, " carry"},          64'(carry),     64'(ec));
        $display("txn %s: mul a=0x%h b=0x%h y=0x%h zero=%0d carry=%0d",
                 tag, va, vb, y, zero, carry);
        step();
        check_idle({tag, " after consume"});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        select = 3'b000; a = '0; b = '0;
        step();
        step();
        check("reset y",     64'(y),     64'd0);
        check("reset zero",  64'(zero),  64'd0);
        check("reset carry", 64'(carry), 64'd0);
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("post reset");
        $display("txn reset: in_ready=%0d out_valid=%0d busy=%0d", in_ready, out_valid, busy);

        run_simple("add wrap",  3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
        run_simple("add plain", 3'b001, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);
        run_simple("and",       3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0);
        run_simple("xor",       3'b100, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0);
        run_simple("slt 5<7",   3'b101, 32'd5,         32'd7,         32'd1,         1'b0, 1'b0);
        run_simple("slt 7<5",   3'b101, 32'd7,         32'd5,         32'd0,         1'b1, 1'b0);
        run_simple("slt unsgn", 3'b101, 32'h0000_0001, 32'h8000_0000, 32'd1,         1'b0, 1'b0);
        run_simple("pass a",    3'b111, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
        run_simple("op zero",   3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);

        run_mul("mul 3x5",   32'd3,         32'd5,         32'd15,        1'b0, 1'b0);
        run_mul("mul 2^32",  32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1);
        run_mul("mul ffff2", 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b0);
        run_mul("mul max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);

        // Backpressure: OR result held for 5 stalled cycles while new requests are offered.
        select = 3'b011; a = 32'h1200_0034; b = 32'h0056_7800; in_valid = 1'b1; out_ready = 1'b0;
        step();
        select = 3'b001; a = 32'hFFFF_FFFF; b = 32'h0000_0001;
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp in_ready",  64'(in_ready),  64'd0);
            check("bp y",         64'(y),         64'h1256_7834);
            check("bp zero",      64'(zero),      64'd0);
            check("bp carry",     64'(carry),     64'd0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp y before consume", 64'(y), 64'h1256_7834);
        step();
        check_idle("bp after consume");
        check("bp y hold", 64'(y), 64'h1256_7834);
        step();
        check_idle("bp no queued request");
        $display("txn backpressure: or result 0x%h held 5 cycles", 32'h1256_7834);

        // Reset during a multiply: no result must appear afterwards.
        select = 3'b110; a = 32'd3; b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) step();
        check("abort busy before", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort y", 64'(y), 64'd0);
        check_idle("abort");
        for (int i = 0; i < 40; i++) begin
            check("abort no pulse", 64'(out_valid), 64'd0);
            step();
        end
        $display("txn abort: reset during multiply, out_valid stayed low");

        // Back-to-back after abort still works.
        run_simple("add post abort", 3'b001, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operation request is present.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port select, input, 3, meaning the opcode.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, meaning the operands.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result outputs are valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL have port y, output, WIDTH, meaning the registered result.
REQ-011 The block SHALL have port zero, output, 1, meaning y is all zeros.
REQ-012 The block SHALL have port carry, output, 1, meaning add carry-out or multiply overflow.
REQ-013 The block SHALL have port busy, output, 1, meaning a multiply is in progress.

Function
REQ-014 Opcodes SHALL be: 001 a+b; 010 a&b; 011 a|b; 100 a^b; 101 unsigned (a<b)?1:0; 110 a*b (low WIDTH bits); 111 pass a; 000 y=0.
REQ-015 The FSM SHALL have states IDLE, MUL, DONE; in_ready=1 only in IDLE; busy=1 only in MUL; out_valid=1 only in DONE.
REQ-016 A request SHALL be accepted on a cycle with state IDLE and in_valid=1; select, a, b are latched at acceptance; later input changes are ignored until the next acceptance.
REQ-017 Non-multiply opcodes SHALL go IDLE->DONE; y/zero/carry are registered at acceptance; out_valid rises the cycle after acceptance (latency 1).
REQ-018 Multiply SHALL go IDLE->MUL; one shift-add step per cycle over exactly WIDTH cycles counted by a $clog2(WIDTH+1)-bit counter; then ->DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-019 Multiply SHALL form the full 2*WIDTH-bit unsigned product internally; y = low WIDTH bits; carry=1 iff the high WIDTH bits are nonzero.
REQ-020 Add SHALL set carry to the bit-WIDTH carry-out; all opcodes other than add and multiply SHALL set carry=0.
REQ-021 zero SHALL equal (y==0) for every opcode, including 000 (zero=1).
REQ-022 In DONE, y/zero/carry SHALL hold stable while out_ready=0; when out_ready=1 the state SHALL return to IDLE next cycle, with out_valid=0 and in_ready=1.
REQ-023 No request SHALL be accepted in the same cycle a result is consumed; minimum initiation interval is 2 cycles for non-multiply ops.
REQ-024 Undefined select values SHALL not exist (all 8 decoded); in_valid in MUL or DONE SHALL have no effect.

Reset
REQ-025 reset=1 SHALL force state IDLE, counter 0, y=0, zero=0, carry=0, out_valid=0, busy=0; in_ready=1 from the cycle after reset.
REQ-026 reset SHALL take priority over all other inputs and abort an in-progress multiply or pending result with no output pulse.

Verification (WIDTH=32)
REQ-027 Add 0xFFFFFFFF+0x00000001 accepted at cycle 0 -> cycle 1: out_valid=1, y=0, zero=1, carry=1.
REQ-028 Multiply 3*5 accepted at cycle 0 -> busy=1 cycles 1-32, out_valid=1 at cycle 33, y=15, carry=0, zero=0.
REQ-029 Multiply 0x00010000*0x00010000 -> y=0, zero=1, carry=1 at cycle 33.
REQ-030 SLT a=5, b=7 -> y=1; a=7, b=5 -> y=0, zero=1; XOR 0xA5A5A5A5^0xFFFFFFFF -> y=0x5A5A5A5A.
REQ-031 Backpressure: OR result with out_ready=0 for 5 cycles -> out_valid and y held constant, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-032 Reset asserted at cycle 10 of a multiply -> next cycle out_valid=0, busy=0, in_ready=1, y=0; no result ever appears for the aborted operation.
